mul_div_unit: RTL and testbench

- Multi-cycle signed multiply/divide engine. Consumes the 32-bit bus output; produces the 64-bit Z result whose halves drive the bus mux Z-high and Z-low inputs.
- Operand A is latched into an internal Y register from the bus under yin. Operand B is taken from the bus in the start cycle.
- The control sequencer issues start and waits for done before asserting the Z-high/Z-low bus selects.

---
 rtl/mul_div_unit_pkg.sv | 17 +
 rtl/mdu_iter_core.sv | 51 +++++
 rtl/mul_div_unit.sv | 152 +++++++++++++++
 tb/tb_mul_div_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - shared encodings and constants for the multiply/divide engine
package mul_div_unit_pkg;

  // Operation select, sampled together with start
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Iterations per MUL/DIV; one operand bit is consumed per cycle
  localparam int ITER_COUNT = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_iter_core.sv
// rtl/mdu_iter_core.sv - one combinational Booth or restoring-divide iteration
module mdu_iter_core
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               op_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  logic [2*WIDTH:0]   work_i,
  output logic [2*WIDTH:0]   work_o
);

  // Work layout: [2W:W+1] = acc / remainder, [W:1] = multiplier / quotient,
  // [0] = Booth q-1 (unused for divide).
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             qm1;

  assign hi  = work_i[2*WIDTH:WIDTH+1];
  assign lo  = work_i[WIDTH:1];
  assign qm1 = work_i[0];

  // The Booth sum is kept one bit wider than the accumulator so that adding
  // or subtracting the most negative multiplicand cannot overflow before the
  // arithmetic shift; the extra bit becomes the shifted-in sign.
  logic [WIDTH:0] booth_sum;
  logic [WIDTH:0] trial_rem;
  logic [WIDTH:0] trial_diff;

  // Booth add/shift or restore-subtract/shift selected by op
  always_comb begin
    booth_sum = {hi[WIDTH-1], hi};
    case ({lo[0], qm1})
      2'b01:   booth_sum = {hi[WIDTH-1], hi} + {operand_i[WIDTH-1], operand_i};
      2'b10:   booth_sum = {hi[WIDTH-1], hi} - {operand_i[WIDTH-1], operand_i};
      default: booth_sum = {hi[WIDTH-1], hi};
    endcase

    trial_rem  = {hi, lo[WIDTH-1]};
    trial_diff = trial_rem - {1'b0, operand_i};

    if (op_i == OP_MUL) begin
      work_o = {booth_sum, lo};
    end else if (!trial_diff[WIDTH]) begin
      work_o = {trial_diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1, 1'b0};
    end else begin
      work_o = {trial_rem[WIDTH-1:0], lo[WIDTH-2:0], 1'b0, 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle signed multiply/divide engine with Y operand register
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             yin,
  input  logic             start,
  input  logic             op,
  output logic [WIDTH-1:0] z_hi,
  output logic [WIDTH-1:0] z_lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(ITER_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);

  logic [WIDTH-1:0]   y_q;
  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               op_q;
  logic [WIDTH-1:0]   a_q;
  logic               sign_b_q;
  logic               zero_div_q;
  logic [WIDTH-1:0]   operand_q;
  logic [2*WIDTH:0]   work_q;
  logic [2*WIDTH:0]   work_d;
  logic [WIDTH-1:0]   z_hi_q;
  logic [WIDTH-1:0]   z_lo_q;
  logic [WIDTH-1:0]   z_hi_d;
  logic [WIDTH-1:0]   z_lo_d;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;

  logic [WIDTH-1:0]   bus_mag;
  logic [WIDTH-1:0]   y_mag;

  assign bus_mag = bus_in[WIDTH-1] ? (~bus_in + 1'b1) : bus_in;
  assign y_mag   = y_q[WIDTH-1]    ? (~y_q + 1'b1)    : y_q;

  mdu_iter_core #(
    .WIDTH (WIDTH)
  ) u_iter_core (
    .op_i      (op_q),
    .operand_i (operand_q),
    .work_i    (work_q),
    .work_o    (work_d)
  );

  // Y operand register, loadable in any state
  always_ff @(posedge clock) begin
    if (clear) begin
      y_q <= '0;
    end else if (yin) begin
      y_q <= bus_in;
    end
  end

  // Sign fix-up of the raw iteration result, or the divide-by-zero pattern
  always_comb begin
    z_hi_d = work_q[2*WIDTH:WIDTH+1];
    z_lo_d = work_q[WIDTH:1];
    if (op_q == OP_DIV) begin
      if (zero_div_q) begin
        z_hi_d = a_q;
        z_lo_d = '1;
      end else begin
        if (a_q[WIDTH-1] ^ sign_b_q) begin
          z_lo_d = ~work_q[WIDTH:1] + 1'b1;
        end
        if (a_q[WIDTH-1]) begin
          z_hi_d = ~work_q[2*WIDTH:WIDTH+1] + 1'b1;
        end
      end
    end
  end

  // Sequencer: capture operands, iterate, then write Z and pulse done
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MUL;
      a_q        <= '0;
      sign_b_q   <= 1'b0;
      zero_div_q <= 1'b0;
      operand_q  <= '0;
      work_q     <= '0;
      z_hi_q     <= '0;
      z_lo_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q       <= op;
            a_q        <= y_q;
            sign_b_q   <= bus_in[WIDTH-1];
            zero_div_q <= (op == OP_DIV) && (bus_in == '0);
            dbz_q      <= 1'b0;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            if (op == OP_MUL) begin
              operand_q <= y_q;
              work_q    <= {{WIDTH{1'b0}}, bus_in, 1'b0};
              state_q   <= S_RUN;
            end else begin
              operand_q <= bus_mag;
              work_q    <= {{WIDTH{1'b0}}, y_mag, 1'b0};
              state_q   <= (bus_in == '0) ? S_FIX : S_RUN;
            end
          end
        end
        S_RUN: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          z_hi_q  <= z_hi_d;
          z_lo_q  <= z_lo_d;
          dbz_q   <= zero_div_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign z_hi        = z_hi_q;
  assign z_lo        = z_lo_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed vector bench for mul_div_unit
module tb_mul_div_unit;

  localparam logic MUL = 1'b0;
  localparam logic DIV = 1'b1;

  logic        clock;
  logic        clear;
  logic [31:0] bus_in;
  logic        yin;
  logic        start;
  logic        op;
  logic [31:0] z_hi;
  logic [31:0] z_lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[13];

  mul_div_unit #(
    .WIDTH (32)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .bus_in      (bus_in),
    .yin         (yin),
    .start       (start),
    .op          (op),
    .z_hi        (z_hi),
    .z_lo        (z_lo),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // All tasks are entered at a falling edge and leave at a falling edge
  task automatic load_y(input logic [31:0] a);
    bus_in = a;
    yin    = 1'b1;
    @(negedge clock);
    yin    = 1'b0;
  endtask

  task automatic start_op(input logic [31:0] b, input logic o);
    bus_in = b;
    op     = o;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
  endtask

  // k counts rising edges since the start edge; entry is at sample k0
  task automatic wait_done(input int k0, input int exp_lat, input string nm);
    int lat;
    int nbusy;
    lat   = -1;
    nbusy = 0;
    for (int k = k0; k <= k0 + 45; k++) begin
      if (k > k0) @(negedge clock);
      if (done) begin
        lat = k;
        break;
      end
      if (busy) nbusy++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_busy_cycles"}, 64'(nbusy), 64'(exp_lat - k0));
    chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clock);
    chk({nm, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{MUL, 32'd6,        32'd7,        32'h00000000, 32'h0000002A, 1'b0};
    vecs[1]  = '{MUL, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2]  = '{MUL, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[3]  = '{MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[4]  = '{MUL, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
    vecs[5]  = '{DIV, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[6]  = '{DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[7]  = '{DIV, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
    vecs[8]  = '{DIV, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{DIV, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0};
    vecs[10] = '{DIV, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1};
    vecs[11] = '{MUL, 32'd2,        32'd3,        32'h00000000, 32'h00000006, 1'b0};
    vecs[12] = '{DIV, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};

    clear  = 1'b1;
    bus_in = '0;
    yin    = 1'b0;
    start  = 1'b0;
    op     = MUL;
    repeat (2) @(negedge clock);
    clear  = 1'b0;
    chk("reset_z_hi", 64'(z_hi), 64'd0);
    chk("reset_z_lo", 64'(z_lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_dbz",  64'(div_by_zero), 64'd0);

    for (int i = 0; i < 13; i++) begin
      int exp_lat;
      exp_lat = (vecs[i].op == DIV && vecs[i].b == 32'd0) ? 1 : 33;
      load_y(vecs[i].a);
      start_op(vecs[i].b, vecs[i].op);
      chk($sformatf("vec%0d_busy_start", i), 64'(busy), 64'd1);
      wait_done(0, exp_lat, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_z_hi", i), 64'(z_hi), 64'(vecs[i].hi));
      chk($sformatf("vec%0d_z_lo", i), 64'(z_lo), 64'(vecs[i].lo));
      chk($sformatf("vec%0d_dbz", i),  64'(div_by_zero), 64'(vecs[i].dbz));
    end

    // Start and Y load while busy: start ignored, Y updated for later
    load_y(32'd6);
    start_op(32'd7, MUL);
    repeat (9) @(negedge clock);
    bus_in = 32'd9;
    op     = DIV;
    start  = 1'b1;
    yin    = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    yin    = 1'b0;
    wait_done(10, 33, "busy_start");
    chk("busy_start_z_hi", 64'(z_hi), 64'd0);
    chk("busy_start_z_lo", 64'(z_lo), 64'd42);
    start_op(32'd1, MUL);
    wait_done(0, 33, "y_after_busy");
    chk("y_after_busy_z_lo", 64'(z_lo), 64'd9);

    // New start accepted in the done cycle itself
    begin
      int seen;
      seen = 0;
      load_y(32'd4);
      start_op(32'd5, MUL);
      for (int k = 1; k <= 45; k++) begin
        @(negedge clock);
        if (done) begin
          seen = 1;
          break;
        end
      end
      chk("b2b_done_seen", 64'(seen), 64'd1);
      chk("b2b_first_z_lo", 64'(z_lo), 64'd20);
      start_op(32'd3, MUL);
      wait_done(0, 33, "b2b_second");
      chk("b2b_second_z_lo", 64'(z_lo), 64'd12);
    end

    // Clear mid-operation aborts without writing Z
    begin
      int dcount;
      load_y(32'd2);
      start_op(32'd2, MUL);
      repeat (9) @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      chk("abort_z_hi", 64'(z_hi), 64'd0);
      chk("abort_z_lo", 64'(z_lo), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      dcount = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clock);
        if (done) dcount++;
      end
      chk("abort_no_done", 64'(dcount), 64'd0);
      load_y(32'd3);
      start_op(32'd3, MUL);
      wait_done(0, 33, "after_abort");
      chk("after_abort_z_lo", 64'(z_lo), 64'd9);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
